// File: rtl/fmaflags_pipe.sv
// fmaflags_pipe
//   Last FMA pipeline stage. It resolves special cases (NaN, infinity and
//   invalid operations), applies overflow saturation according to the
//   dynamic rounding mode, and produces the flags {nv, dz, of, uf, nx}.
//   There is one output register with a valid/ready handshake.
//
//   Optional feature: define FMAFLAGS_ACCUM_EN to add a sticky flag
//   accumulator for the fflags CSR. This adds the ports acc_clr and
//   acc_flags.
//
// Ports
//   clk, reset_n           clock (rising edge), async active-low reset
//   in_valid / in_ready    input handshake
//   xs, ys, zs             operand signs
//   x/y/z snan, nan        signalling NaN / any NaN per operand
//   x/y/z inf, zero        infinity / zero class per operand
//   g, r, s, asticky       guard, round, sticky, addend sticky
//   senorm  [NE+1:0]       signed normalised biased exponent
//   int_result [W-1:0]     rounded result from the rounder
//   rm [2:0]               rounding mode (RNE,RZ,RDN,RUP,RMM; others = RNE)
//   out_valid / out_ready  output handshake
//   result [W-1:0]         final result
//   flags [4:0]            {nv, dz, of, uf, nx}; dz is always 0
//   acc_clr, acc_flags     accumulator clear / value (FMAFLAGS_ACCUM_EN only)
module fmaflags_pipe #(
  parameter int NE = 5,
  parameter int NF = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                xs,
  input  logic                ys,
  input  logic                zs,
  input  logic                xsnan,
  input  logic                ysnan,
  input  logic                zsnan,
  input  logic                xnan,
  input  logic                ynan,
  input  logic                znan,
  input  logic                xinf,
  input  logic                yinf,
  input  logic                zinf,
  input  logic                xzero,
  input  logic                yzero,
  input  logic                zzero,
  input  logic                g,
  input  logic                r,
  input  logic                s,
  input  logic                asticky,
  input  logic [NE+1:0]       senorm,
  input  logic [NE+NF:0]      int_result,
  input  logic [2:0]          rm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NE+NF:0]      result,
  output logic [4:0]          flags
`ifdef FMAFLAGS_ACCUM_EN
  ,
  input  logic                acc_clr,
  output logic [4:0]          acc_flags
`endif
);

  localparam int W = 1 + NE + NF;

  localparam logic [W-1:0]  QNAN = {1'b0, {NE{1'b1}}, 1'b1, {(NF-1){1'b0}}};
  localparam logic [NE+1:0] EMAX = (NE+2)'((1 << NE) - 1);

  localparam logic [2:0] RM_RZ  = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;

  logic [W-1:0] res_d, result_q;
  logic [4:0]   flags_d, flags_q;
  logic         out_valid_q, out_valid_d;
  logic         nv_d, of_d, uf_d, nx_d;

  logic any_snan, any_nan, inf_cancel, inf_times_zero;
  logic ovf, tiny, inexact, sg;
  logic accept, handshake;

  assign any_snan       = xsnan | ysnan | zsnan;
  assign any_nan        = xnan | ynan | znan;
  // Infinite product added to an infinite addend of opposite effective sign.
  assign inf_cancel     = (xinf | yinf) & zinf & (xs ^ ys ^ zs);
  assign inf_times_zero = (xinf & yzero) | (xzero & yinf);

  // senorm is signed: a large negative exponent must not look like overflow.
  assign ovf     = $signed(senorm) >= $signed(EMAX);
  assign tiny    = senorm[NE+1] | (senorm == '0);
  assign inexact = g | r | s | asticky;
  assign sg      = int_result[W-1];

  always_comb begin
    res_d = int_result;
    nv_d  = 1'b0;
    of_d  = 1'b0;
    uf_d  = 1'b0;
    nx_d  = 1'b0;
    if (any_snan) begin
      res_d = QNAN;
      nv_d  = 1'b1;
    end else if (any_nan) begin
      res_d = QNAN;
    end else if (inf_cancel | inf_times_zero) begin
      res_d = QNAN;
      nv_d  = 1'b1;
    end else if (xinf | yinf) begin
      res_d = {xs ^ ys, {NE{1'b1}}, {NF{1'b0}}};
    end else if (zinf) begin
      res_d = {zs, {NE{1'b1}}, {NF{1'b0}}};
    end else if (ovf) begin
      of_d = 1'b1;
      nx_d = 1'b1;
      // The default is infinity; each directed mode saturates toward zero
      // on the side it rounds away from.
      res_d = {sg, {NE{1'b1}}, {NF{1'b0}}};
      case (rm)
        RM_RZ:  res_d = {sg, {(NE-1){1'b1}}, 1'b0, {NF{1'b1}}};
        RM_RDN: if (!sg) res_d = {1'b0, {(NE-1){1'b1}}, 1'b0, {NF{1'b1}}};
        RM_RUP: if (sg)  res_d = {1'b1, {(NE-1){1'b1}}, 1'b0, {NF{1'b1}}};
        default: ;
      endcase
    end else begin
      uf_d = tiny & inexact;
      nx_d = inexact;
    end
  end

  assign flags_d = {nv_d, 1'b0, of_d, uf_d, nx_d};

  assign in_ready  = !out_valid_q | out_ready;
  assign accept    = in_valid & in_ready;
  assign handshake = out_valid_q & out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    if (accept)         out_valid_d = 1'b1;
    else if (handshake) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (accept) begin
        result_q <= res_d;
        flags_q  <= flags_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

`ifdef FMAFLAGS_ACCUM_EN
  logic [4:0] acc_q, acc_d;

  // The clear applies first, so a beat completing in the same cycle still counts.
  always_comb begin
    acc_d = acc_clr ? 5'b0 : acc_q;
    if (handshake) acc_d = acc_d | flags_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) acc_q <= '0;
    else          acc_q <= acc_d;
  end

  assign acc_flags = acc_q;
`endif

endmodule

// File: tb/tb_fmaflags_pipe.sv
module tb_fmaflags_pipe;

  typedef struct packed {
    logic xs, ys, zs, xsnan, ysnan, zsnan, xnan, ynan, znan;
    logic xinf, yinf, zinf, xzero, yzero, zzero;
    logic g, r, s, asticky;
    logic [6:0]  senorm;
    logic [15:0] int_result;
    logic [2:0]  rm;
  } in_t;

  typedef struct {
    in_t         in;
    logic [15:0] exp_res;
    logic [4:0]  exp_flags;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic xs, ys, zs, xsnan, ysnan, zsnan, xnan, ynan, znan;
  logic xinf, yinf, zinf, xzero, yzero, zzero, g, r, s, asticky;
  logic [6:0]  senorm;
  logic [15:0] int_result, result;
  logic [2:0]  rm;
  logic [4:0]  flags;
`ifdef FMAFLAGS_ACCUM_EN
  logic        acc_clr = 1'b0;
  logic [4:0]  acc_flags;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fmaflags_pipe #(.NE(5), .NF(10)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .xs(xs), .ys(ys), .zs(zs),
    .xsnan(xsnan), .ysnan(ysnan), .zsnan(zsnan),
    .xnan(xnan), .ynan(ynan), .znan(znan),
    .xinf(xinf), .yinf(yinf), .zinf(zinf),
    .xzero(xzero), .yzero(yzero), .zzero(zzero),
    .g(g), .r(r), .s(s), .asticky(asticky),
    .senorm(senorm), .int_result(int_result), .rm(rm),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
`ifdef FMAFLAGS_ACCUM_EN
    , .acc_clr(acc_clr), .acc_flags(acc_flags)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_in(input in_t v);
    {xs, ys, zs, xsnan, ysnan, zsnan, xnan, ynan, znan} =
      {v.xs, v.ys, v.zs, v.xsnan, v.ysnan, v.zsnan, v.xnan, v.ynan, v.znan};
    {xinf, yinf, zinf, xzero, yzero, zzero} = {v.xinf, v.yinf, v.zinf, v.xzero, v.yzero, v.zzero};
    {g, r, s, asticky} = {v.g, v.r, v.s, v.asticky};
    senorm = v.senorm;
    int_result = v.int_result;
    rm = v.rm;
  endtask

  // Presents one beat for a single cycle with the consumer ready, then
  // returns half a cycle after the loading edge.
  task automatic send(input in_t v);
    @(negedge clk);
    apply_in(v);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Reference model: the rule list evaluated directly with integer arithmetic.
  function automatic logic [20:0] model(input in_t v);
    int e;
    logic inx, sign;
    logic [15:0] inf_v, max_v, res;
    e = $signed(v.senorm);
    inx = v.g | v.r | v.s | v.asticky;
    if (v.xsnan | v.ysnan | v.zsnan) return {16'h7e00, 5'b10000};
    if (v.xnan | v.ynan | v.znan) return {16'h7e00, 5'b00000};
    if ((v.xinf | v.yinf) && v.zinf && (v.xs ^ v.ys ^ v.zs)) return {16'h7e00, 5'b10000};
    if ((v.xinf && v.yzero) || (v.xzero && v.yinf)) return {16'h7e00, 5'b10000};
    if (v.xinf | v.yinf) return {(v.xs ^ v.ys) ? 16'hfc00 : 16'h7c00, 5'b00000};
    if (v.zinf) return {v.zs ? 16'hfc00 : 16'h7c00, 5'b00000};
    if (e >= 31) begin
      sign  = v.int_result[15];
      inf_v = sign ? 16'hfc00 : 16'h7c00;
      max_v = sign ? 16'hfbff : 16'h7bff;
      if (v.rm == 3'd1)      res = max_v;
      else if (v.rm == 3'd2) res = sign ? inf_v : max_v;
      else if (v.rm == 3'd3) res = sign ? max_v : inf_v;
      else                   res = inf_v;
      return {res, 5'b00101};
    end
    return {v.int_result, 2'b00, 1'b0, (e <= 0) && inx, inx};
  endfunction

  function automatic logic rare();
    return $urandom_range(0, 11) == 0;
  endfunction

  function automatic in_t rand_in();
    in_t v;
    v = '0;
    {v.xs, v.ys, v.zs} = 3'($urandom_range(0, 7));
    {v.xsnan, v.ysnan, v.zsnan} = {rare() & rare(), rare() & rare(), rare() & rare()};
    {v.xnan, v.ynan, v.znan} = {rare(), rare(), rare()};
    {v.xinf, v.yinf, v.zinf} = {rare(), rare(), rare()};
    {v.xzero, v.yzero, v.zzero} = {rare(), rare(), rare()};
    {v.g, v.r, v.s, v.asticky} = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
    if ($urandom_range(0, 4) == 0) v.senorm = 7'($urandom);
    else v.senorm = 7'($signed($urandom_range(0, 44)) - 8);
    v.int_result = 16'($urandom);
    v.rm = 3'($urandom_range(0, 7));
    return v;
  endfunction

  vec_t tbl[$];

  task automatic add(input in_t v, input logic [15:0] er, input logic [4:0] ef);
    vec_t t;
    t.in = v; t.exp_res = er; t.exp_flags = ef;
    tbl.push_back(t);
  endtask

  initial begin
    in_t v, va, vb;
    logic [20:0] exq[$];
    logic [20:0] exp_v;
    logic [15:0] held_res;
    logic [4:0]  held_flags, acc_m;
    logic stall_prev, hs, acc_now;

    apply_in('0);

    // Directed vectors: inputs, then hand-derived expected result and flags.
    v = '0; v.xsnan = 1; add(v, 16'h7e00, 5'b10000);
    v = '0; v.xinf = 1; v.zinf = 1; v.zs = 1; add(v, 16'h7e00, 5'b10000);
    v = '0; v.senorm = 7'd31; v.g = 1; v.int_result = 16'h3c00;
    v.rm = 3'd0; add(v, 16'h7c00, 5'b00101);
    v.rm = 3'd1; add(v, 16'h7bff, 5'b00101);
    v.rm = 3'd2; add(v, 16'h7bff, 5'b00101);
    v.rm = 3'd3; add(v, 16'h7c00, 5'b00101);
    v.rm = 3'd4; add(v, 16'h7c00, 5'b00101);
    v.rm = 3'd6; add(v, 16'h7c00, 5'b00101);
    v.int_result = 16'hbc00;
    v.rm = 3'd1; add(v, 16'hfbff, 5'b00101);
    v.rm = 3'd2; add(v, 16'hfc00, 5'b00101);
    v.rm = 3'd3; add(v, 16'hfbff, 5'b00101);
    v = '0; v.senorm = 7'd40; v.int_result = 16'h1234; add(v, 16'h7c00, 5'b00101);
    v = '0; v.senorm = 7'd30; v.g = 1; v.int_result = 16'h7bff; add(v, 16'h7bff, 5'b00001);
    v = '0; v.senorm = 7'd15; v.r = 1; v.int_result = 16'h3c01; add(v, 16'h3c01, 5'b00001);
    v = '0; v.senorm = 7'd15; v.int_result = 16'h3c01; add(v, 16'h3c01, 5'b00000);
    v = '0; v.senorm = 7'd0; v.s = 1; v.int_result = 16'h0123; add(v, 16'h0123, 5'b00011);
    v = '0; v.senorm = 7'd0; v.int_result = 16'h0123; add(v, 16'h0123, 5'b00000);
    v = '0; v.senorm = 7'd1; v.g = 1; v.int_result = 16'h0400; add(v, 16'h0400, 5'b00001);
    v = '0; v.senorm = 7'h7d; v.asticky = 1; v.int_result = 16'h8001; add(v, 16'h8001, 5'b00011);
    v = '0; v.senorm = 7'h40; v.s = 1; v.int_result = 16'h0002; add(v, 16'h0002, 5'b00011);
    v = '0; v.ynan = 1; v.g = 1; add(v, 16'h7e00, 5'b00000);
    v = '0; v.ysnan = 1; v.znan = 1; add(v, 16'h7e00, 5'b10000);
    v = '0; v.xzero = 1; v.yinf = 1; add(v, 16'h7e00, 5'b10000);
    v = '0; v.xinf = 1; v.ys = 1; v.g = 1; add(v, 16'hfc00, 5'b00000);
    v = '0; v.xinf = 1; v.zinf = 1; v.xs = 1; v.ys = 1; add(v, 16'h7c00, 5'b00000);
    v = '0; v.zinf = 1; v.zs = 1; v.g = 1; add(v, 16'hfc00, 5'b00000);
    v = '0; v.xinf = 1; v.senorm = 7'd31; v.g = 1; add(v, 16'h7c00, 5'b00000);

    // Reset state
    #3;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_flags", flags, 0);
`ifdef FMAFLAGS_ACCUM_EN
    chk("reset_acc_flags", acc_flags, 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      send(tbl[i].in);
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_result", i), result, tbl[i].exp_res);
      chk($sformatf("vec%0d_flags", i), flags, tbl[i].exp_flags);
    end

    // Backpressure: beat A stalls for three cycles while beat B waits.
    va = '0; va.senorm = 7'd15; va.g = 1; va.int_result = 16'h3c01;
    vb = '0; vb.xsnan = 1;
    @(negedge clk);
    apply_in(va); in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    apply_in(vb);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_held_valid", out_valid, 1);
      chk("bp_held_result", result, 16'h3c01);
      chk("bp_held_flags", flags, 5'b00001);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second_result", result, 16'h7e00);
    chk("bp_second_flags", flags, 5'b10000);
    @(negedge clk);
    chk("bp_drained", out_valid, 0);

`ifdef FMAFLAGS_ACCUM_EN
    @(negedge clk); acc_clr = 1'b1;
    @(negedge clk); acc_clr = 1'b0;
    chk("acc_clr_alone", acc_flags, 0);
    send(va);
    send(vb);
    @(negedge clk);
    chk("acc_nx_then_nv", acc_flags, 5'b10001);
    v = '0; v.senorm = 7'd31; v.int_result = 16'h3c00;
    send(v);
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    chk("acc_clr_with_hs", acc_flags, 5'b00101);
`endif

    // Reset while a stalled beat is in flight.
    @(negedge clk);
    apply_in(va); in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_pre_valid", out_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_result", result, 0);
    chk("rst_async_flags", flags, 0);
`ifdef FMAFLAGS_ACCUM_EN
    chk("rst_async_acc", acc_flags, 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    v = '0; v.zinf = 1; v.zs = 1;
    send(v);
    chk("rst_latency_valid", out_valid, 1);
    chk("rst_latency_result", result, 16'hfc00);

    // Randomized traffic against the reference model and a scoreboard queue.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b0;
`ifdef FMAFLAGS_ACCUM_EN
    acc_clr = 1'b1;
`endif
    @(negedge clk);
`ifdef FMAFLAGS_ACCUM_EN
    acc_clr = 1'b0;
`endif
    acc_m = '0;
    stall_prev = 1'b0;
    held_res = '0;
    held_flags = '0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (stall_prev) begin
        chk("rnd_hold_result", result, held_res);
        chk("rnd_hold_flags", flags, held_flags);
      end
      v = rand_in();
      apply_in(v);
      in_valid = i < 590 ? ($urandom_range(0, 3) != 0) : 1'b0;
      out_ready = i < 590 ? ($urandom_range(0, 3) != 0) : 1'b1;
      acc_now = 1'b0;
`ifdef FMAFLAGS_ACCUM_EN
      acc_clr = $urandom_range(0, 15) == 0;
      acc_now = acc_clr;
`endif
      #1;
      chk("rnd_out_valid", out_valid, exq.size() != 0);
      chk("rnd_in_ready", in_ready, (exq.size() == 0) | out_ready);
`ifdef FMAFLAGS_ACCUM_EN
      chk("rnd_acc_flags", acc_flags, acc_m);
`endif
      hs = (exq.size() != 0) && out_ready;
      if (acc_now) acc_m = '0;
      if (hs) begin
        exp_v = exq.pop_front();
        chk("rnd_result", result, exp_v[20:5]);
        chk("rnd_flags", flags, exp_v[4:0]);
        acc_m = acc_m | exp_v[4:0];
      end
      stall_prev = (exq.size() != 0) && !out_ready;
      held_res = result;
      held_flags = flags;
      if (in_valid && ((exq.size() == 0) || out_ready)) exq.push_back(model(v));
    end
    @(negedge clk);
    chk("rnd_drain_empty", exq.size(), 0);
    chk("rnd_drain_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fmaflags_pipe.md
# fmaflags_pipe

Parametrised, registered special-case and exception-flag resolution stage for the FMA datapath. It takes operand classifications, the rounded intermediate result, the round/sticky bits and the normalised exponent. It produces the final IEEE-754 result and the per-operation flags {nv, dz, of, uf, nx}. It sits after the rounder as the last pipeline stage, uses a valid/ready handshake, honours the dynamic rounding mode on overflow, and can accumulate flags sticky-style for the fflags CSR.

## Interface
Parameters:
- NE, 5, exponent width.
- NF, 10, fraction width; result width W = 1+NE+NF.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  stage can accept a beat.
- xs, ys, zs  in  1 each  operand signs.
- xsnan, ysnan, zsnan, xnan, ynan, znan  in  1 each  signalling / any NaN.
- xinf, yinf, zinf, xzero, yzero, zzero  in  1 each  infinity / zero classes.
- g, r, s, asticky  in  1 each  guard, round, sticky, addend sticky.
- senorm  in  NE+2  signed normalised biased exponent.
- int_result  in  W  rounded result from rounder.
- rm  in  3  rounding mode: 000 RNE, 001 RZ, 010 RDN, 011 RUP, 100 RMM; 101–111 treated as RNE.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts.
- result  out  W  final result.
- flags  out  5  {nv, dz, of, uf, nx} for the current result; dz is always 0.
- acc_clr  in  1  synchronous clear of accumulated flags (present only with FMAFLAGS_ACCUM_EN).
- acc_flags  out  5  OR-accumulated flags (present only with FMAFLAGS_ACCUM_EN).

## Operation
- The canonical NaN is {0, all-ones exponent, 1, zeros}; for the defaults this is 16'h7e00.
- maxnorm(sg) = {sg, all-ones exponent minus 1, all-ones fraction}.
- inf(sg) = {sg, all-ones exponent, zeros}.
- Combinational resolution uses the first matching rule, in this priority order:
  1. Any sNaN: canonical NaN, nv=1.
  2. Any NaN: canonical NaN, nv=0.
  3. (xinf|yinf) & zinf & (xs^ys^zs): canonical NaN, nv=1.
  4. (xinf&yzero)|(xzero&yinf): canonical NaN, nv=1.
  5. xinf|yinf: inf(xs^ys).
  6. zinf: inf(zs).
  7. Overflow when senorm >= 2^NE−1 (signed compare). of=1. The result sign is sg = int_result[W−1]:
     - RNE/RMM: inf(sg).
     - RZ: maxnorm(sg).
     - RDN: sg ? inf(1) : maxnorm(0).
     - RUP: sg ? maxnorm(1) : inf(0).
  8. Otherwise result = int_result.
- uf = (senorm <= 0, signed) & (g|r|s|asticky), evaluated only under rule 8.
- nx = g|r|s|asticky|of|uf under rules 7–8. nx is forced to 0 under rules 1–6.

## Timing
- One output register stage; latency 1 cycle from an accepted input to out_valid.
- in_ready = !out_valid | out_ready (combinational pass-through of out_ready).
- An input beat is accepted when in_valid & in_ready. On that edge, result and flags load and out_valid is set to 1.
- An output beat completes when out_valid & out_ready. Without a simultaneous accept, out_valid clears.
- While out_valid & !out_ready, result and flags hold stable and in_ready is 0. No beat is dropped or duplicated.
- Full throughput: with both valid and ready held high, one beat completes per cycle.
- Reset values (async, immediate on reset_n low): out_valid=0, result=0, flags=0, acc_flags=0. A beat in flight is discarded.
- Accumulator update, on output handshake: acc_flags |= flags.
- acc_clr alone: acc_flags becomes 0 on the next edge.
- acc_clr coinciding with a handshake: acc_flags becomes the handshaken flags (clear takes effect first, then the OR).

## Configuration
- FMAFLAGS_ACCUM_EN defined: the acc_clr/acc_flags ports and the accumulator register exist, behaving as described above.
- FMAFLAGS_ACCUM_EN undefined: those ports and the register are absent. All other behaviour is identical.

## Test plan
- xsnan=1, rm=RNE -> one cycle later result=16'h7e00, flags=5'b10000.
- xinf=1, zinf=1, xs=0, ys=0, zs=1 -> result=16'h7e00, nv=1, nx=0.
- senorm=31, int_result sign 0, g=1, swept over rm: RNE -> 16'h7c00; RZ -> 16'h7bff; RDN -> 16'h7bff; RUP -> 16'h7c00. Each case has flags=5'b00101.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 and two different beats -> in_ready=0, the first result is held stable. After ready, beats emerge in order with no loss.
- Accumulation (ACCUM_EN):
  - Beat with nx, then beat with nv -> acc_flags=5'b10001.
  - acc_clr pulsed together with a handshake carrying of+nx -> acc_flags=5'b00101.
- reset_n asserted while out_valid=1 and out_ready=0 -> out_valid=0 and acc_flags=0 immediately. After release, the first new beat has latency 1.
